// File: rtl/bitstream_byte_feeder_pkg.sv
// Shared decoder package: byte type, emulation-prevention byte value,
// default byte FIFO depth and the per-word byte count limit.
package bitstream_byte_feeder_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t      EPB_BYTE           = 8'h03;
    localparam int         DEFAULT_FIFO_DEPTH = 8;
    localparam logic [2:0] MAX_NBYTES         = 3'd4;

    // Number of bytes to unpack from a word: full word unless it is the last
    // one, and out-of-range counts on the last word fall back to a full word.
    function automatic logic [2:0] word_nbytes(input logic last, input logic [2:0] nbytes);
        logic [2:0] n;
        if (!last) begin
            n = MAX_NBYTES;
        end else if ((nbytes == 3'd0) || (nbytes > MAX_NBYTES)) begin
            n = MAX_NBYTES;
        end else begin
            n = nbytes;
        end
        return n;
    endfunction

endpackage

// File: rtl/bitstream_byte_feeder_fifo.sv
// byte_fifo: show-ahead byte FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module byte_fifo
    import bitstream_byte_feeder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  byte_t push_data,
    input  logic  pop,
    output byte_t head,
    output logic  not_empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    byte_t       mem_r [DEPTH];
    logic        empty_s;
    logic        full_s;
    logic        do_push_s;
    logic        do_pop_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign do_pop_s  = pop & ~empty_s;
    assign do_push_s = push & (~full_s | do_pop_s);

    assign head      = empty_s ? 8'h00 : mem_r[rd_ptr_r[AW-1:0]];
    assign not_empty = ~empty_s;
    assign full      = full_s;

    // Pointer update; both pointers wrap naturally through the extra bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bitstream_byte_feeder.sv
// bitstream_byte_feeder: unpacks big-endian 32-bit bitstream words into a
// show-ahead byte FIFO feeding the arithmetic decoder.
// Optional feature macro EPB_REMOVAL_EN: drops an 8'h03 emulation-prevention
// byte that follows two or more pushed 8'h00 bytes and counts the drops.
module bitstream_byte_feeder
    import bitstream_byte_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        in_ready,
    input  logic        request_byte,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        stream_end,
    output logic        underflow,
    output logic [15:0] epb_count
);

    logic [31:0] word_r;
    logic [2:0]  cnt_r;
    logic        last_r;
    logic        last_seen_r;
    logic        underflow_r;
    logic        rst_d_r;
    logic [15:0] epb_cnt_s;

    logic        blank_s;
    byte_t       cur_byte_s;
    byte_t       head_s;
    logic        fifo_ne_s;
    logic        fifo_full_s;
    logic        pop_s;
    logic        step_s;
    logic        drop_s;
    logic        push_s;
    logic        in_ready_s;
    logic        accept_s;

    // Outputs are forced quiet while reset is high and for one cycle after.
    assign blank_s    = reset | rst_d_r;
    assign cur_byte_s = word_r[31:24];
    assign pop_s      = request_byte & fifo_ne_s & ~blank_s;
    assign step_s     = (cnt_r != 3'd0) & (~fifo_full_s | pop_s);
    assign push_s     = step_s & ~drop_s;
    assign in_ready_s = ~blank_s & ~last_r & ~last_seen_r &
                        ((cnt_r == 3'd0) | ((cnt_r == 3'd1) & step_s));
    assign accept_s   = in_valid & in_ready_s;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (cur_byte_s),
        .pop       (pop_s),
        .head      (head_s),
        .not_empty (fifo_ne_s),
        .full      (fifo_full_s)
    );

    // Unpack register: load on accept, otherwise shift out one byte per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= 32'h0000_0000;
            cnt_r  <= 3'd0;
            last_r <= 1'b0;
        end else if (accept_s) begin
            word_r <= in_word;
            cnt_r  <= word_nbytes(in_last, in_nbytes);
            last_r <= in_last;
        end else if (step_s) begin
            word_r <= {word_r[23:0], 8'h00};
            cnt_r  <= cnt_r - 3'd1;
        end
    end

    // Status flags: last-seen, sticky underflow and the post-reset quiet cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_seen_r <= 1'b0;
            underflow_r <= 1'b0;
            rst_d_r     <= 1'b1;
        end else begin
            rst_d_r <= 1'b0;
            if (step_s && (cnt_r == 3'd1) && last_r) begin
                last_seen_r <= 1'b1;
            end
            if (request_byte && !fifo_ne_s && !blank_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef EPB_REMOVAL_EN
    logic [1:0]  zero_run_r;
    logic [15:0] epb_cnt_r;

    assign drop_s    = step_s & (cur_byte_s == EPB_BYTE) & (zero_run_r == 2'd2);
    assign epb_cnt_s = epb_cnt_r;

    // Zero-run tracking across words and saturating count of dropped bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_run_r <= 2'd0;
            epb_cnt_r  <= 16'h0000;
        end else if (step_s) begin
            if (drop_s) begin
                zero_run_r <= 2'd0;
                if (epb_cnt_r != 16'hFFFF) begin
                    epb_cnt_r <= epb_cnt_r + 16'h0001;
                end
            end else if (cur_byte_s == 8'h00) begin
                if (zero_run_r != 2'd2) begin
                    zero_run_r <= zero_run_r + 2'd1;
                end
            end else begin
                zero_run_r <= 2'd0;
            end
        end
    end
`else
    assign drop_s    = 1'b0;
    assign epb_cnt_s = 16'h0000;
`endif

    assign in_ready   = in_ready_s;
    assign data       = blank_s ? 8'h00 : head_s;
    assign data_valid = fifo_ne_s & ~blank_s;
    assign stream_end = last_seen_r & ~fifo_ne_s & ~blank_s;
    assign underflow  = underflow_r & ~blank_s;
    assign epb_count  = blank_s ? 16'h0000 : epb_cnt_s;

endmodule
